// File: rtl/mio_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : mio_bus_ctrl_if
// Brief  : CPU-side request/response bundle for the memory/IO bus controller.
// Rev    : 1.0  initial release
// ============================================================================
interface mio_bus_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              mem_w;
  logic [31:0]       addr_bus;
  logic [DATA_W-1:0] cpu_data2bus;
  logic [DATA_W-1:0] cpu_data4bus;
  logic              ready;
  logic              bus_err;

  modport master (
    output req, mem_w, addr_bus, cpu_data2bus,
    input  cpu_data4bus, ready, bus_err
  );

  modport slave (
    input  req, mem_w, addr_bus, cpu_data2bus,
    output cpu_data4bus, ready, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mio_bus_ctrl
// Brief  : Latches CPU requests, decodes RAM / IO slots, sequences strobes,
//          wait states and IO timeouts, and returns data with a ready pulse.
// Rev    : 1.0  initial release
// ============================================================================
module mio_bus_ctrl #(
  parameter int DATA_W   = 32,
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int N_IO     = 4,
  parameter int IO_BASE  = 4'hC,
  parameter int TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  mio_bus_ctrl_if.slave          cpu,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data_in,
  output logic                   data_ram_we,
  input  logic [DATA_W-1:0]      ram_data_out,
  output logic [N_IO-1:0]        io_sel,
  output logic                   io_we,
  output logic [DATA_W-1:0]      peripheral_in,
  input  logic [N_IO*DATA_W-1:0] io_rdata,
  input  logic [N_IO-1:0]        io_ack
);

  localparam int                WAIT_W    = $clog2(16);
  localparam int                TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RAM_WAIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic                r_we, r_err;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [3:0]          r_slot;
  logic [WAIT_W-1:0]   r_wait;
  logic [TO_W-1:0]     r_to;

  logic                w_ram_hit, w_io_hit;
  logic [3:0]          w_io_nib, w_io_slot;
  logic                w_ack;
  logic [DATA_W-1:0]   w_slot_rdata;
  logic [N_IO-1:0]     w_sel_oh;
  logic                w_accept, w_ready, w_ram_done, w_io_timeout;

  // Address decode on the live bus; only used on the accept edge.
  always_comb begin
    w_io_nib  = cpu.addr_bus[11:8];
    w_io_slot = w_io_nib - 4'(IO_BASE);
    w_ram_hit = (cpu.addr_bus[31:RAM_AW+2] == '0);
    w_io_hit  = (cpu.addr_bus[31:12] == 20'hFFFFF) &&
                (w_io_nib >= 4'(IO_BASE)) &&
                ({1'b0, w_io_slot} < 5'(N_IO));
  end

  // Per-slot selection of ack, read data and the one-hot select.
  always_comb begin
    w_ack        = 1'b0;
    w_slot_rdata = '0;
    w_sel_oh     = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (r_slot == 4'(k)) begin
        w_ack        = io_ack[k];
        w_slot_rdata = io_rdata[k*DATA_W +: DATA_W];
        w_sel_oh[k]  = 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_ready      = 1'b0;
    data_ram_we  = 1'b0;
    io_we        = 1'b0;
    io_sel       = '0;
    w_ram_done   = 1'b0;
    w_io_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu.req) begin
          w_accept = 1'b1;
          if (w_ram_hit)     w_next = RAM_ACC;
          else if (w_io_hit) w_next = IO_ACC;
          else               w_next = RESP;
        end
      end
      RAM_ACC: begin
        data_ram_we = r_we && (r_wait == '0);
        if (r_wait == WAIT_LAST) begin
          w_ram_done = 1'b1;
          w_next     = RESP;
        end
      end
      IO_ACC: begin
        io_sel = w_sel_oh;
        io_we  = r_we && (r_to == '0);
        if (w_ack) begin
          w_next = RESP;
        end else if (r_to == TO_LAST) begin
          w_io_timeout = 1'b1;
          w_next       = RESP;
        end
      end
      RESP: begin
        w_ready = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_ram_addr <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_slot     <= '0;
      r_wait     <= '0;
      r_to       <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= cpu.mem_w;
        r_ram_addr <= cpu.addr_bus[RAM_AW+1:2];
        r_wdata    <= cpu.cpu_data2bus;
        r_slot     <= w_io_slot;
        r_err      <= !(w_ram_hit || w_io_hit);
        r_wait     <= '0;
        r_to       <= '0;
        if (!w_ram_hit && !w_io_hit && !cpu.mem_w)
          r_rdata <= '0;
      end
      if (r_state == RAM_ACC) begin
        r_wait <= r_wait + WAIT_W'(1);
        if (w_ram_done && !r_we)
          r_rdata <= ram_data_out;
      end
      if (r_state == IO_ACC) begin
        r_to <= r_to + TO_W'(1);
        if (w_ack && !r_we)
          r_rdata <= w_slot_rdata;
        // A read that times out returns zero rather than stale data.
        if (w_io_timeout) begin
          r_err <= 1'b1;
          if (!r_we)
            r_rdata <= '0;
        end
      end
    end
  end

  assign ram_addr         = r_ram_addr;
  assign ram_data_in      = r_wdata;
  assign peripheral_in    = r_wdata;
  assign cpu.cpu_data4bus = r_rdata;
  assign cpu.ready        = w_ready;
  assign cpu.bus_err      = w_ready & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mio_bus_ctrl
// Brief  : Randomized self-checking bench for mio_bus_ctrl with a
//          transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mio_bus_ctrl;

  localparam int DATA_W   = 32;
  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 1;
  localparam int N_IO     = 4;
  localparam int IO_BASE  = 4'hC;
  localparam int TIMEOUT  = 15;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [RAM_AW-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_data_in;
  logic                   data_ram_we;
  logic [DATA_W-1:0]      ram_data_out;
  logic [N_IO-1:0]        io_sel;
  logic                   io_we;
  logic [DATA_W-1:0]      peripheral_in;
  logic [N_IO*DATA_W-1:0] io_rdata;
  logic [N_IO-1:0]        io_ack;

  int total = 0;
  int bad   = 0;

  mio_bus_ctrl_if #(.DATA_W(DATA_W)) bus ();

  mio_bus_ctrl #(
    .DATA_W(DATA_W), .RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT),
    .N_IO(N_IO), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cpu(bus),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .data_ram_we(data_ram_we),
    .ram_data_out(ram_data_out), .io_sel(io_sel), .io_we(io_we),
    .peripheral_in(peripheral_in), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  // RAM device: the controller's strobes are the only way data gets in.
  logic [DATA_W-1:0] ram_mem [0:(1<<RAM_AW)-1] = '{default: '0};
  assign ram_data_out = ram_mem[ram_addr];
  always @(posedge clk) if (data_ram_we) ram_mem[ram_addr] <= ram_data_in;

  // Reference model state: memory contents and the CPU's read register.
  logic [DATA_W-1:0] model_mem [int];
  logic [DATA_W-1:0] exp_rd;

  typedef struct {
    int                kind;   // 0 RAM, 1 IO, 2 unmapped
    int                slot;
    int                lat;
    logic              err;
    logic [DATA_W-1:0] rd;
  } exp_t;

  typedef struct {
    int                lat;
    logic              err;
    logic [DATA_W-1:0] rd;
    int                ram_we_n;
    int                ram_we_cyc;
    logic [RAM_AW-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    int                io_we_n;
    int                io_we_cyc;
    logic [DATA_W-1:0] pdata;
    int                sel_n;
    int                sel_bad;
  } obs_t;

  function automatic logic [DATA_W-1:0] mem_lookup(int idx);
    return model_mem.exists(idx) ? model_mem[idx] : '0;
  endfunction

  function automatic exp_t predict(bit w, logic [31:0] a, int ack_at, logic [DATA_W-1:0] io_val);
    exp_t e;
    int   nib = int'(a[11:8]);
    e.slot = -1;
    if (a < (32'd1 << (RAM_AW + 2))) begin
      e.kind = 0; e.lat = RAM_WAIT + 1; e.err = 1'b0;
      e.rd   = w ? exp_rd : mem_lookup(int'(a >> 2));
    end else if ((a >> 12) == 32'hFFFFF && nib >= IO_BASE && nib < IO_BASE + N_IO) begin
      e.kind = 1; e.slot = nib - IO_BASE;
      if (ack_at >= 1 && ack_at <= TIMEOUT) begin
        e.lat = ack_at + 1; e.err = 1'b0; e.rd = w ? exp_rd : io_val;
      end else begin
        e.lat = TIMEOUT + 1; e.err = 1'b1; e.rd = w ? exp_rd : '0;
      end
    end else begin
      e.kind = 2; e.lat = 1; e.err = 1'b1; e.rd = w ? exp_rd : '0;
    end
    return e;
  endfunction

  task automatic model_commit(input bit w, input logic [31:0] a, input logic [DATA_W-1:0] d, input exp_t e);
    if (e.kind == 0 && w) model_mem[int'(a >> 2)] = d;
    exp_rd = e.rd;
  endtask

  // Drives one request and records what the DUT did, cycle by cycle after accept.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [DATA_W-1:0] d,
                         input int ack_at, input int slot, input logic [DATA_W-1:0] io_val,
                         input bit hold, output obs_t o);
    logic [N_IO-1:0] mask;
    o = '{default: 0};
    o.lat = -1;
    mask = (slot >= 0) ? N_IO'(1) << slot : '0;
    @(negedge clk);
    bus.req = 1'b1; bus.mem_w = w; bus.addr_bus = a; bus.cpu_data2bus = d;
    io_ack = '0;
    for (int k = 0; k < N_IO; k++)
      io_rdata[k*DATA_W +: DATA_W] = (k == slot) ? io_val : DATA_W'($urandom);
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!hold) begin
        bus.req = 1'b0; bus.mem_w = 1'($urandom);
        bus.addr_bus = $urandom; bus.cpu_data2bus = DATA_W'($urandom);
      end
      if (data_ram_we) begin
        o.ram_we_n++; o.ram_we_cyc = c; o.we_addr = ram_addr; o.we_data = ram_data_in;
      end
      if (io_we) begin
        o.io_we_n++; o.io_we_cyc = c; o.pdata = peripheral_in;
      end
      if (io_sel != '0) begin
        o.sel_n++;
        if (io_sel !== mask) o.sel_bad++;
      end
      if (bus.ready === 1'b1) begin
        o.lat = c; o.err = bus.bus_err; o.rd = bus.cpu_data4bus;
        io_ack = '0; bus.req = 1'b0;
        break;
      end
      io_ack = (N_IO'($urandom) & ~mask) | ((ack_at >= 1 && c >= ack_at) ? mask : '0);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({bus.ready, bus.bus_err, data_ram_we, io_we} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got %b want 0000", {bus.ready, bus.bus_err, data_ram_we, io_we});
    end
    total++;
    if (io_sel !== '0) begin
      bad++; $display("FAIL reset_io_sel got %b want 0", io_sel);
    end
    total++;
    if (bus.cpu_data4bus !== '0 || ram_addr !== '0 || ram_data_in !== '0 || peripheral_in !== '0) begin
      bad++; $display("FAIL reset_regs got rd=%h ra=%h rdi=%h pi=%h want all 0",
                      bus.cpu_data4bus, ram_addr, ram_data_in, peripheral_in);
    end
  endtask

  task automatic test_ram;
    obs_t o; exp_t e;
    e = predict(1'b1, 32'h10, 0, '0);
    run_txn(1'b1, 32'h10, 32'hA5A5_0001, 0, -1, '0, 1'b0, o);
    total++;
    if (o.ram_we_n !== 1 || o.ram_we_cyc !== 1 || o.we_addr !== 10'd4 || o.we_data !== 32'hA5A5_0001) begin
      bad++; $display("FAIL ram_wr_strobe got n=%0d cyc=%0d addr=%0d data=%h want n=1 cyc=1 addr=4 data=a5a50001",
                      o.ram_we_n, o.ram_we_cyc, o.we_addr, o.we_data);
    end
    total++;
    if (o.lat !== 2 || o.err !== 1'b0) begin
      bad++; $display("FAIL ram_wr_ready got lat=%0d err=%b want lat=2 err=0", o.lat, o.err);
    end
    model_commit(1'b1, 32'h10, 32'hA5A5_0001, e);
    e = predict(1'b0, 32'h10, 0, '0);
    run_txn(1'b0, 32'h10, 32'h0, 0, -1, '0, 1'b0, o);
    total++;
    if (o.rd !== 32'hA5A5_0001 || o.lat !== 2 || o.err !== 1'b0 || o.ram_we_n !== 0) begin
      bad++; $display("FAIL ram_rd got data=%h lat=%0d err=%b we=%0d want a5a50001 2 0 0",
                      o.rd, o.lat, o.err, o.ram_we_n);
    end
    model_commit(1'b0, 32'h10, 32'h0, e);
  endtask

  task automatic test_io;
    obs_t o; exp_t e;
    e = predict(1'b0, 32'hFFFF_FE00, 3, 32'h1234);
    run_txn(1'b0, 32'hFFFF_FE00, 32'h0, 3, 2, 32'h0000_1234, 1'b0, o);
    total++;
    if (o.sel_n !== 3 || o.sel_bad !== 0 || o.io_we_n !== 0) begin
      bad++; $display("FAIL io_sel got cycles=%0d wrong=%0d we=%0d want 3 0 0", o.sel_n, o.sel_bad, o.io_we_n);
    end
    total++;
    if (o.lat !== 4 || o.rd !== 32'h1234 || o.err !== 1'b0) begin
      bad++; $display("FAIL io_rd got lat=%0d data=%h err=%b want 4 00001234 0", o.lat, o.rd, o.err);
    end
    model_commit(1'b0, 32'hFFFF_FE00, 32'h0, e);
  endtask

  task automatic test_timeout;
    obs_t o; exp_t e;
    e = predict(1'b0, 32'hFFFF_FF04, 0, 32'hDEAD);
    run_txn(1'b0, 32'hFFFF_FF04, 32'h0, 0, 3, 32'hDEAD, 1'b0, o);
    total++;
    if (o.lat !== 16 || o.err !== 1'b1 || o.rd !== 32'h0 || o.sel_n !== 15) begin
      bad++; $display("FAIL io_timeout got lat=%0d err=%b data=%h sel=%0d want 16 1 0 15",
                      o.lat, o.err, o.rd, o.sel_n);
    end
    model_commit(1'b0, 32'hFFFF_FF04, 32'h0, e);
  endtask

  task automatic test_unmapped;
    obs_t o; exp_t e;
    e = predict(1'b1, 32'h1234_0000, 0, '0);
    run_txn(1'b1, 32'h1234_0000, 32'hCAFE_F00D, 0, -1, '0, 1'b0, o);
    total++;
    if (o.ram_we_n !== 0 || o.io_we_n !== 0 || o.sel_n !== 0) begin
      bad++; $display("FAIL unmapped_strobe got ram=%0d io=%0d sel=%0d want 0 0 0", o.ram_we_n, o.io_we_n, o.sel_n);
    end
    total++;
    if (o.lat !== 1 || o.err !== 1'b1) begin
      bad++; $display("FAIL unmapped_ready got lat=%0d err=%b want 1 1", o.lat, o.err);
    end
    model_commit(1'b1, 32'h1234_0000, 32'hCAFE_F00D, e);
  endtask

  task automatic test_busy;
    obs_t o; exp_t e; int extra;
    e = predict(1'b0, 32'hFFFF_FC00, 2, 32'h5555_AAAA);
    run_txn(1'b0, 32'hFFFF_FC00, 32'h0, 2, 0, 32'h5555_AAAA, 1'b1, o);
    model_commit(1'b0, 32'hFFFF_FC00, 32'h0, e);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ready || io_sel != '0 || data_ram_we || io_we) extra++;
    end
    total++;
    if (o.lat !== 3 || o.rd !== 32'h5555_AAAA || o.sel_n !== 2 || extra !== 0) begin
      bad++; $display("FAIL busy_single got lat=%0d data=%h sel=%0d extra=%0d want 3 5555aaaa 2 0",
                      o.lat, o.rd, o.sel_n, extra);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t e; int seen;
    @(negedge clk);
    bus.req = 1'b1; bus.mem_w = 1'b0; bus.addr_bus = 32'hFFFF_FD00; io_ack = '0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    total++;
    if (io_sel !== 4'b0010) begin
      bad++; $display("FAIL rst_mid_pre_sel got %b want 0010", io_sel);
    end
    rst = 1'b0;
    #1;
    total++;
    if (io_sel !== '0 || bus.ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_drop got sel=%b ready=%b want 0 0", io_sel, bus.ready);
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    rst = 1'b1;
    exp_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rst_mid_ready got %0d pulses want 0", seen);
    end
    e = predict(1'b0, 32'h10, 0, '0);
    run_txn(1'b0, 32'h10, 32'h0, 0, -1, '0, 1'b0, o);
    total++;
    if (o.lat !== e.lat || o.rd !== e.rd || o.err !== e.err) begin
      bad++; $display("FAIL rst_mid_after got lat=%0d data=%h err=%b want %0d %h %b",
                      o.lat, o.rd, o.err, e.lat, e.rd, e.err);
    end
    model_commit(1'b0, 32'h10, 32'h0, e);
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    bit w; logic [31:0] a; logic [DATA_W-1:0] d, iv; int ack_at;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); d = DATA_W'($urandom); iv = DATA_W'($urandom);
      ack_at = $urandom_range(0, TIMEOUT + 2);
      case ($urandom_range(0, 3))
        0, 1: a = (i % 3 == 0) ? {$urandom_range(0, 1023), 2'b00} : {$urandom_range(0, 7), 2'b00};
        2:    a = {20'hFFFFF, 4'($urandom_range(0, 15)), 8'($urandom)};
        default: a = $urandom | 32'h0001_0000;
      endcase
      e = predict(w, a, ack_at, iv);
      run_txn(w, a, d, ack_at, e.slot, iv, 1'b0, o);
      total++;
      if (o.lat !== e.lat || o.err !== e.err) begin
        bad++; $display("FAIL rnd%0d_resp got lat=%0d err=%b want %0d %b", i, o.lat, o.err, e.lat, e.err);
      end
      total++;
      if (o.rd !== e.rd) begin
        bad++; $display("FAIL rnd%0d_data got %h want %h", i, o.rd, e.rd);
      end
      total++;
      if (o.ram_we_n !== ((e.kind == 0 && w) ? 1 : 0) ||
          (o.ram_we_n == 1 && (o.ram_we_cyc !== 1 || o.we_addr !== a[RAM_AW+1:2] || o.we_data !== d))) begin
        bad++; $display("FAIL rnd%0d_ram_we got n=%0d cyc=%0d addr=%h data=%h want n=%0d addr=%h data=%h",
                        i, o.ram_we_n, o.ram_we_cyc, o.we_addr, o.we_data, (e.kind == 0 && w) ? 1 : 0,
                        a[RAM_AW+1:2], d);
      end
      total++;
      if (o.io_we_n !== ((e.kind == 1 && w) ? 1 : 0) || (o.io_we_n == 1 && (o.io_we_cyc !== 1 || o.pdata !== d))) begin
        bad++; $display("FAIL rnd%0d_io_we got n=%0d cyc=%0d data=%h want n=%0d data=%h",
                        i, o.io_we_n, o.io_we_cyc, o.pdata, (e.kind == 1 && w) ? 1 : 0, d);
      end
      total++;
      if (o.sel_n !== ((e.kind == 1) ? e.lat - 1 : 0) || o.sel_bad !== 0) begin
        bad++; $display("FAIL rnd%0d_io_sel got cycles=%0d wrong=%0d want %0d 0",
                        i, o.sel_n, o.sel_bad, (e.kind == 1) ? e.lat - 1 : 0);
      end
      model_commit(w, a, d, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 1'b0; bus.mem_w = 1'b0; bus.addr_bus = '0; bus.cpu_data2bus = '0;
    io_rdata = '0; io_ack = '0;
    exp_rd = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_ram;
    test_io;
    test_timeout;
    test_unmapped;
    test_busy;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
